// File: rtl/spi_slave_to_wb_master_if.sv
// Wishbone pipelined 8-bit bus between the SPI frame decoder (master) and a register slave.
interface spi_slave_to_wb_master_if;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic [AW-1:0] m_wb_addr;
    logic [DW-1:0] m_wb_dat_m2s;
    logic [DW-1:0] m_wb_dat_s2m;
    logic          m_wb_we;
    logic          m_wb_sel;
    logic          m_wb_stb;
    logic          m_wb_cyc;
    logic          m_wb_ack;
    logic          m_wb_stall;

    modport master (
        output m_wb_addr, m_wb_dat_m2s, m_wb_we, m_wb_sel, m_wb_stb, m_wb_cyc,
        input  m_wb_dat_s2m, m_wb_ack, m_wb_stall
    );

    modport slave (
        input  m_wb_addr, m_wb_dat_m2s, m_wb_we, m_wb_sel, m_wb_stb, m_wb_cyc,
        output m_wb_dat_s2m, m_wb_ack, m_wb_stall
    );
endinterface

// File: rtl/spi_slave_to_wb_master.sv
// SPI mode-0 slave oversampled in the clk domain; decodes CMD/ADDR/data frames into
// single-outstanding Wishbone pipelined cycles on the internal 8-bit register space.
module spi_slave_to_wb_master #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  RD_FAIL_BYTE = 8'hFF
) (
    input  logic clk,
    input  logic aresetn,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic miso,
    spi_slave_to_wb_master_if.master wb
);
    localparam int unsigned DW = 8;
    localparam int unsigned BW = 3;

    typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_WDATA, F_TURN, F_RDATA, F_RDONE} frame_st_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wb_st_e;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic sck_s, ss_s, mosi_s, sck_d, ss_d;
    logic sck_rise_c, sck_fall_c, ss_rise_c, ss_fall_c;

    frame_st_e frame_st, frame_nxt;
    wb_st_e    wb_st, wb_nxt;

    logic [BW-1:0] bit_cnt;
    logic [DW-2:0] rx_shift;
    logic [DW-1:0] rx_byte_c, tx_shift, tx_byte_c, ptr, req_addr_c, rd_data;
    logic          wr_mode, byte_done_c, wb_idle_c, wb_req_c, req_we_c;
    logic          rd_owned, rd_valid, ack_take_c, cyc_nxt, stb_nxt;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_rise_c  = sck_s & ~sck_d;
    assign sck_fall_c  = ~sck_s & sck_d;
    assign ss_rise_c   = ss_s & ~ss_d;
    assign ss_fall_c   = ~ss_s & ss_d;
    assign rx_byte_c   = {rx_shift, mosi_s};
    assign byte_done_c = sck_rise_c & ~ss_s & (bit_cnt == BW'(7)) & (frame_st != F_IDLE);
    assign wb_idle_c   = (wb_st == W_IDLE);
    assign tx_byte_c   = (frame_st == F_RDATA) ? (rd_valid ? rd_data : RD_FAIL_BYTE) : DW'(0);
    assign miso        = tx_shift[DW-1];

    // Pin synchronisers and edge history
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_st <= F_IDLE;
        end else begin
            frame_st <= frame_nxt;
        end
    end

    // Frame sequencing; a rising ss always wins over a coincident byte completion
    always_comb begin
        frame_nxt  = frame_st;
        wb_req_c   = 1'b0;
        req_we_c   = 1'b0;
        req_addr_c = ptr;
        if (ss_rise_c) begin
            frame_nxt = F_IDLE;
        end else if (ss_fall_c) begin
            frame_nxt = F_CMD;
        end else if (byte_done_c) begin
            case (frame_st)
                F_CMD:   frame_nxt = F_ADDR;
                F_ADDR: begin
                    if (wr_mode) begin
                        frame_nxt = F_WDATA;
                    end else begin
                        frame_nxt  = F_TURN;
                        wb_req_c   = wb_idle_c;
                        req_addr_c = rx_byte_c;
                    end
                end
                F_WDATA: begin
                    wb_req_c = wb_idle_c;
                    req_we_c = 1'b1;
                end
                F_TURN:  frame_nxt = F_RDATA;
                F_RDATA: frame_nxt = F_RDONE;
                default: ;
            endcase
        end
    end

    // Shift registers, bit counter, command mode and address pointer
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            wr_mode  <= 1'b0;
            ptr      <= '0;
        end else begin
            if (ss_s || ss_fall_c) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
            end else begin
                if (sck_rise_c && frame_st != F_IDLE) begin
                    bit_cnt  <= bit_cnt + BW'(1);
                    rx_shift <= rx_byte_c[DW-2:0];
                end
                if (sck_fall_c) begin
                    tx_shift <= (bit_cnt == '0) ? tx_byte_c : {tx_shift[DW-2:0], 1'b0};
                end
            end
            if (byte_done_c && !ss_fall_c) begin
                case (frame_st)
                    F_CMD:   wr_mode <= rx_byte_c[0];
                    F_ADDR:  ptr     <= rx_byte_c;
                    F_WDATA: if (wb_idle_c) ptr <= ptr + DW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Wishbone cycle sequencing
    always_comb begin
        wb_nxt     = wb_st;
        cyc_nxt    = wb.m_wb_cyc;
        stb_nxt    = wb.m_wb_stb;
        ack_take_c = 1'b0;
        case (wb_st)
            W_IDLE: begin
                if (wb_req_c) begin
                    wb_nxt  = W_REQ;
                    cyc_nxt = 1'b1;
                    stb_nxt = 1'b1;
                end
            end
            W_REQ: begin
                if (!wb.m_wb_stall) begin
                    stb_nxt = 1'b0;
                    if (wb.m_wb_ack) begin
                        wb_nxt     = W_IDLE;
                        cyc_nxt    = 1'b0;
                        ack_take_c = 1'b1;
                    end else begin
                        wb_nxt = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wb.m_wb_ack) begin
                    wb_nxt     = W_IDLE;
                    cyc_nxt    = 1'b0;
                    ack_take_c = 1'b1;
                end
            end
            default: begin
                wb_nxt  = W_IDLE;
                cyc_nxt = 1'b0;
                stb_nxt = 1'b0;
            end
        endcase
    end

    // Wishbone registers; read data is kept only for the read owned by the current frame
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wb_st           <= W_IDLE;
            wb.m_wb_cyc     <= 1'b0;
            wb.m_wb_stb     <= 1'b0;
            wb.m_wb_addr    <= '0;
            wb.m_wb_dat_m2s <= '0;
            wb.m_wb_we      <= 1'b0;
            wb.m_wb_sel     <= 1'b1;
            rd_owned        <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
        end else begin
            wb_st       <= wb_nxt;
            wb.m_wb_cyc <= cyc_nxt;
            wb.m_wb_stb <= stb_nxt;
            wb.m_wb_sel <= 1'b1;
            if (wb_req_c) begin
                wb.m_wb_addr    <= req_addr_c;
                wb.m_wb_dat_m2s <= req_we_c ? rx_byte_c : DW'(0);
                wb.m_wb_we      <= req_we_c;
            end
            if (ss_fall_c || ss_rise_c) begin
                rd_owned <= 1'b0;
                rd_valid <= 1'b0;
            end else begin
                if (wb_req_c && !req_we_c) begin
                    rd_owned <= 1'b1;
                end
                if (ack_take_c && !wb.m_wb_we && rd_owned) begin
                    rd_valid <= 1'b1;
                    rd_data  <= wb.m_wb_dat_s2m;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_to_wb_master.sv
// Bench for spi_slave_to_wb_master: SPI master driver, Wishbone slave model and a
// scoreboard that checks every accepted Wishbone request against queued expectations.
module tb_spi_slave_to_wb_master;
    localparam int HP = 8;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] dat;
    } wb_exp_t;

    logic clk;
    logic aresetn, sck, ss, mosi, miso;
    int   checks, errors;
    int   cfg_stall, cfg_ack;
    logic [7:0] cfg_rdata;
    logic [7:0] txb [8];
    logic [7:0] rxb [8];
    wb_exp_t exp_q [$];

    spi_slave_to_wb_master_if bus ();

    spi_slave_to_wb_master #(
        .SYNC_STAGES (2),
        .RD_FAIL_BYTE(8'hFF)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .sck    (sck),
        .ss     (ss),
        .mosi   (mosi),
        .miso   (miso),
        .wb     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic we, input logic [7:0] addr, input logic [7:0] dat);
        wb_exp_t e;
        e.we   = we;
        e.addr = addr;
        e.dat  = dat;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [7:0] b0, b1, b2, b3, b4);
        txb[0] = b0; txb[1] = b1; txb[2] = b2; txb[3] = b3; txb[4] = b4;
    endtask

    // One mode-0 byte (or its first nbits), MSB first; miso sampled at each rise
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (HP) @(negedge clk);
            sck = 1'b1;
            rx = {rx[6:0], miso};
            repeat (HP) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int n);
        ss = 1'b0;
        repeat (HP) @(negedge clk);
        for (int k = 0; k < n; k++) spi_byte(txb[k], 8, rxb[k]);
        repeat (HP) @(negedge clk);
        ss = 1'b1;
        repeat (4 * HP) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (bus.m_wb_cyc && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_cyc_done"}, 32'(n < 2000), 32'd1);
        chk({tag, "_all_cycles_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Wishbone slave model: holds stall for cfg_stall cycles, acks cfg_ack cycles after acceptance
    initial begin
        int ph, cnt;
        ph = 0;
        cnt = 0;
        bus.m_wb_stall   = 1'b0;
        bus.m_wb_ack     = 1'b0;
        bus.m_wb_dat_s2m = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bus.m_wb_ack     = 1'b0;
            bus.m_wb_dat_s2m = cfg_rdata;
            case (ph)
                0: if (bus.m_wb_cyc && bus.m_wb_stb) begin
                    if (cfg_stall > 0) begin
                        bus.m_wb_stall = 1'b1;
                        cnt = cfg_stall - 1;
                        ph = 1;
                    end else begin
                        bus.m_wb_stall = 1'b0;
                        cnt = cfg_ack;
                        ph = 2;
                    end
                end
                1: if (cnt == 0) begin
                    bus.m_wb_stall = 1'b0;
                    cnt = cfg_ack;
                    ph = 2;
                end else begin
                    cnt--;
                end
                default: if (cnt <= 1) begin
                    bus.m_wb_ack = 1'b1;
                    ph = 0;
                end else begin
                    cnt--;
                end
            endcase
        end
    end

    // Scoreboard monitor: a request is accepted at the next posedge when stb && !stall now
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (aresetn && bus.m_wb_cyc && bus.m_wb_stb && !bus.m_wb_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cycle: got we=%0d addr=%0h dat=%0h expected none",
                             bus.m_wb_we, bus.m_wb_addr, bus.m_wb_dat_m2s);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_we", 32'(bus.m_wb_we), 32'(e.we));
                    chk("wb_addr", 32'(bus.m_wb_addr), 32'(e.addr));
                    if (e.we) chk("wb_dat", 32'(bus.m_wb_dat_m2s), 32'(e.dat));
                    chk("wb_sel", 32'(bus.m_wb_sel), 32'd1);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        checks    = 0;
        errors    = 0;
        aresetn   = 1'b0;
        sck       = 1'b0;
        ss        = 1'b1;
        mosi      = 1'b0;
        cfg_stall = 0;
        cfg_ack   = 1;
        cfg_rdata = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_addr", 32'(bus.m_wb_addr), 32'd0);
        chk("rst_dat", 32'(bus.m_wb_dat_m2s), 32'd0);
        chk("rst_we", 32'(bus.m_wb_we), 32'd0);
        chk("rst_stb", 32'(bus.m_wb_stb), 32'd0);
        chk("rst_cyc", 32'(bus.m_wb_cyc), 32'd0);
        chk("rst_sel", 32'(bus.m_wb_sel), 32'd1);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);

        // Single write
        cfg_stall = 2; cfg_ack = 2;
        push_exp(1'b1, 8'h10, 8'hAB);
        load(8'h01, 8'h10, 8'hAB, 8'h00, 8'h00);
        run_frame(3);
        for (int k = 0; k < 3; k++) chk($sformatf("w1_miso_b%0d", k), 32'(rxb[k]), 32'h00);
        wait_idle("w1");

        // Burst write with pointer wrap
        cfg_stall = 0; cfg_ack = 3;
        push_exp(1'b1, 8'hFE, 8'h11);
        push_exp(1'b1, 8'hFF, 8'h22);
        push_exp(1'b1, 8'h00, 8'h33);
        load(8'h01, 8'hFE, 8'h11, 8'h22, 8'h33);
        run_frame(5);
        wait_idle("burst");

        // Read with timely ack
        cfg_stall = 2; cfg_ack = 3; cfg_rdata = 8'h5A;
        push_exp(1'b0, 8'h42, 8'h00);
        load(8'h00, 8'h42, 8'h00, 8'h00, 8'h00);
        run_frame(5);
        chk("rd_miso_b1", 32'(rxb[1]), 32'h00);
        chk("rd_miso_b2", 32'(rxb[2]), 32'h00);
        chk("rd_miso_b3", 32'(rxb[3]), 32'h5A);
        chk("rd_miso_b4", 32'(rxb[4]), 32'h00);
        wait_idle("rd");

        // Read whose ack lands after the byte3 boundary
        cfg_stall = 0; cfg_ack = 200; cfg_rdata = 8'h3C;
        push_exp(1'b0, 8'h80, 8'h00);
        load(8'h00, 8'h80, 8'h00, 8'h00, 8'h00);
        run_frame(5);
        chk("late_miso_b3", 32'(rxb[3]), 32'hFF);
        chk("late_miso_b4", 32'(rxb[4]), 32'h00);
        wait_idle("late");

        // Write overrun: second data byte dropped, third goes to pointer+1
        cfg_stall = 0; cfg_ack = 150;
        push_exp(1'b1, 8'h20, 8'hA1);
        push_exp(1'b1, 8'h21, 8'hA3);
        load(8'h01, 8'h20, 8'hA1, 8'hA2, 8'hA3);
        run_frame(5);
        wait_idle("ovr");

        // Abort after 5 address bits, then a clean frame
        cfg_ack = 2;
        ss = 1'b0;
        repeat (HP) @(negedge clk);
        spi_byte(8'h01, 8, r);
        spi_byte(8'h55, 5, r);
        repeat (HP) @(negedge clk);
        ss = 1'b1;
        repeat (4 * HP) @(negedge clk);
        wait_idle("abort");
        push_exp(1'b1, 8'h07, 8'hC3);
        load(8'h01, 8'h07, 8'hC3, 8'h00, 8'h00);
        run_frame(3);
        wait_idle("post_abort");

        // Reset with a stalled cycle outstanding
        cfg_stall = 1000;
        load(8'h01, 8'h30, 8'h77, 8'h00, 8'h00);
        run_frame(3);
        chk("pre_rst_cyc", 32'(bus.m_wb_cyc), 32'd1);
        chk("pre_rst_stb", 32'(bus.m_wb_stb), 32'd1);
        @(posedge clk);
        #1 aresetn = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(bus.m_wb_cyc), 32'd0);
        chk("mid_rst_stb", 32'(bus.m_wb_stb), 32'd0);
        chk("mid_rst_miso", 32'(miso), 32'd0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
